// File: rtl/pck_len_pkg.sv
// Shared types and default widths for the packet-length control slice.
// Imported by the controller, its accumulator and the bench.
package pck_len_pkg;

    localparam int DEF_DATA_WIDTH     = 12;
    localparam int DEF_ADDR_WIDTH     = 5;
    localparam int DEF_DEPTH          = 32;
    localparam int DEF_BYTES_PER_BEAT = 4;
    localparam int DEF_AFULL_TH       = 28;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    typedef logic [DEF_DATA_WIDTH-1:0] len_t;

endpackage

// File: rtl/pck_len_acc.sv
// Per-packet byte accumulator; holds the running length of the open packet
// and produces the saturated final length for the EOP beat.
module pck_len_acc
    import pck_len_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int BYTES_PER_BEAT = DEF_BYTES_PER_BEAT,
    parameter int LB_W           = $clog2(DEF_BYTES_PER_BEAT) + 1
) (
    input  logic                  int_buffer_clk,
    input  logic                  int_buffer_rstn,
    input  logic                  int_buffer_sw_rstn,
    input  logic                  i_start,
    input  logic                  i_incr,
    input  logic                  i_fresh,
    input  logic [LB_W-1:0]       i_last_bytes,
    output logic [DATA_WIDTH-1:0] o_len,
    output logic                  o_sat
);

    localparam int               SUM_W      = DATA_WIDTH + 1;
    localparam logic [SUM_W-1:0] LEN_MAX    = {1'b0, {DATA_WIDTH{1'b1}}};
    localparam logic [SUM_W-1:0] BEAT_BYTES = SUM_W'(BYTES_PER_BEAT);

    logic [SUM_W-1:0] r_acc;
    logic             r_acc_sat;
    logic [SUM_W-1:0] w_lb_eff;
    logic [SUM_W-1:0] w_base;
    logic [SUM_W-1:0] w_incr_sum;
    logic [SUM_W-1:0] w_end_sum;

    function automatic logic [SUM_W-1:0] sat_len(input logic [SUM_W-1:0] v);
        return (v > LEN_MAX) ? LEN_MAX : v;
    endfunction

    // A last_bytes of zero encodes a completely filled final beat.
    assign w_lb_eff   = (i_last_bytes == '0) ? BEAT_BYTES : SUM_W'(i_last_bytes);
    assign w_base     = i_fresh ? '0 : r_acc;
    assign w_incr_sum = r_acc + BEAT_BYTES;
    assign w_end_sum  = w_base + w_lb_eff;

    assign o_len = DATA_WIDTH'(sat_len(w_end_sum));
    assign o_sat = (w_end_sum > LEN_MAX) | (~i_fresh & r_acc_sat);

    always_ff @(posedge int_buffer_clk or negedge int_buffer_rstn) begin
        if (!int_buffer_rstn) begin
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
        end else if (int_buffer_sw_rstn) begin
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
        end else if (i_start) begin
            r_acc     <= BEAT_BYTES;
            r_acc_sat <= 1'b0;
        end else if (i_incr) begin
            r_acc     <= sat_len(w_incr_sum);
            r_acc_sat <= r_acc_sat | (w_incr_sum > LEN_MAX);
        end
    end

endmodule

// File: rtl/pck_len_ctrl.sv
// Control stage for the packet-length buffer: frames ingress packets, writes
// their lengths, owns both pointers and serves downstream length reads.
module pck_len_ctrl
    import pck_len_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int BYTES_PER_BEAT = DEF_BYTES_PER_BEAT,
    parameter int AFULL_TH       = DEF_AFULL_TH
) (
    input  logic                              int_buffer_clk,
    input  logic                              int_buffer_rstn,
    input  logic                              int_buffer_sw_rstn,
    input  logic                              pkt_valid_i,
    input  logic                              pkt_sop_i,
    input  logic                              pkt_eop_i,
    input  logic [$clog2(BYTES_PER_BEAT):0]   pkt_last_bytes_i,
    input  logic                              len_rd_req_i,
    output logic                              wr_en_o,
    output logic [ADDR_WIDTH:0]               wr_addr_o,
    output logic [DATA_WIDTH-1:0]             wr_data_o,
    output logic                              rd_en_o,
    output logic [ADDR_WIDTH:0]               rd_addr_o,
    output logic                              buffer_full_o,
    output logic                              buffer_empty_o,
    output logic [ADDR_WIDTH:0]               fill_cnt_o,
    output logic                              almost_full_o,
    output logic                              len_valid_o,
    output logic                              sop_err_o,
    output logic                              ovf_err_o,
    output logic                              sat_err_o
);

    localparam int               PTR_W     = ADDR_WIDTH + 1;
    localparam int               LB_W      = $clog2(BYTES_PER_BEAT) + 1;
    localparam logic [PTR_W-1:0] FULL_CNT  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_CNT = PTR_W'(AFULL_TH);

    state_t                r_state;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic                  r_wr_en_p1;
    logic [DATA_WIDTH-1:0] r_wr_data_p1;
    logic                  r_len_vld_p1;
    logic                  r_sop_err;
    logic                  r_ovf_err;
    logic                  r_sat_err;

    logic                  w_in_pkt;
    logic                  w_sop_beat;
    logic                  w_eop_beat;
    logic                  w_len_done;
    logic                  w_acc_start;
    logic                  w_acc_incr;
    logic                  w_acc_sat;
    logic [DATA_WIDTH-1:0] w_len;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_full_nxt;
    logic                  w_rd_en;
    logic [PTR_W-1:0]      w_fill;
    logic [PTR_W-1:0]      w_wr_ptr_nxt;
    logic [PTR_W-1:0]      w_rd_ptr_nxt;

    // ---- Stage p0: beat framing and length accumulation ----
    assign w_in_pkt    = (r_state == IN_PKT);
    assign w_sop_beat  = pkt_valid_i & pkt_sop_i;
    assign w_eop_beat  = pkt_valid_i & pkt_eop_i;
    assign w_len_done  = w_eop_beat & (pkt_sop_i | w_in_pkt);
    assign w_acc_start = w_sop_beat & ~pkt_eop_i;
    assign w_acc_incr  = pkt_valid_i & w_in_pkt & ~pkt_sop_i & ~pkt_eop_i;

    pck_len_acc #(
        .DATA_WIDTH     (DATA_WIDTH),
        .BYTES_PER_BEAT (BYTES_PER_BEAT),
        .LB_W           (LB_W)
    ) u_acc (
        .int_buffer_clk     (int_buffer_clk),
        .int_buffer_rstn    (int_buffer_rstn),
        .int_buffer_sw_rstn (int_buffer_sw_rstn),
        .i_start            (w_acc_start),
        .i_incr             (w_acc_incr),
        .i_fresh            (pkt_sop_i),
        .i_last_bytes       (pkt_last_bytes_i),
        .o_len              (w_len),
        .o_sat              (w_acc_sat)
    );

    always_ff @(posedge int_buffer_clk or negedge int_buffer_rstn) begin
        if (!int_buffer_rstn) begin
            r_state <= IDLE;
        end else if (int_buffer_sw_rstn) begin
            r_state <= IDLE;
        end else if (w_sop_beat) begin
            r_state <= pkt_eop_i ? IDLE : IN_PKT;
        end else if (w_eop_beat & w_in_pkt) begin
            r_state <= IDLE;
        end
    end

    // Pointer flags are derived only from registered pointers.
    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                          (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);
    assign w_fill       = r_wr_ptr - r_rd_ptr;
    assign w_rd_en      = len_rd_req_i & ~w_empty;
    assign w_wr_ptr_nxt = r_wr_ptr + PTR_W'(r_wr_en_p1);
    assign w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_rd_en);
    // Fullness of the write cycle is known one cycle early: a read then cannot free room.
    assign w_full_nxt   = ((w_wr_ptr_nxt - w_rd_ptr_nxt) == FULL_CNT);

    // ---- Stage p1: buffer write, pointer update, read valid ----
    always_ff @(posedge int_buffer_clk or negedge int_buffer_rstn) begin
        if (!int_buffer_rstn) begin
            r_wr_en_p1   <= 1'b0;
            r_len_vld_p1 <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_sop_err    <= 1'b0;
            r_ovf_err    <= 1'b0;
            r_sat_err    <= 1'b0;
        end else if (int_buffer_sw_rstn) begin
            r_wr_en_p1   <= 1'b0;
            r_len_vld_p1 <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_sop_err    <= 1'b0;
            r_ovf_err    <= 1'b0;
            r_sat_err    <= 1'b0;
        end else begin
            r_wr_en_p1   <= w_len_done & ~w_full_nxt;
            r_len_vld_p1 <= w_rd_en;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            if (w_sop_beat & w_in_pkt)   r_sop_err <= 1'b1;
            if (w_len_done & w_full_nxt) r_ovf_err <= 1'b1;
            if (w_len_done & w_acc_sat)  r_sat_err <= 1'b1;
        end
    end

    always_ff @(posedge int_buffer_clk or negedge int_buffer_rstn) begin
        if (!int_buffer_rstn) begin
            r_wr_data_p1 <= '0;
        end else if (int_buffer_sw_rstn) begin
            r_wr_data_p1 <= '0;
        end else if (w_len_done & ~w_full_nxt) begin
            r_wr_data_p1 <= w_len;
        end
    end

    assign wr_en_o        = r_wr_en_p1;
    assign wr_addr_o      = r_wr_ptr;
    assign wr_data_o      = r_wr_data_p1;
    assign rd_en_o        = w_rd_en;
    assign rd_addr_o      = r_rd_ptr;
    assign buffer_full_o  = w_full;
    assign buffer_empty_o = w_empty;
    assign fill_cnt_o     = w_fill;
    assign almost_full_o  = (w_fill >= AFULL_CNT);
    assign len_valid_o    = r_len_vld_p1;
    assign sop_err_o      = r_sop_err;
    assign ovf_err_o      = r_ovf_err;
    assign sat_err_o      = r_sat_err;

endmodule

// File: doc/pck_len_ctrl.md
Name: pck_len_ctrl

Overview:
- Upstream control stage for the packet-length buffer (pck_len_buffer). Watches the ingress beat stream (SOP/EOP/valid) and accumulates each packet's byte length.
- Writes each completed length into the buffer; owns the write and read pointers and generates full, empty, fill count and almost-full.
- Serves length-read requests from the downstream packet scheduler and flags framing and overflow errors.

Parameters:
DATA_WIDTH, 12, length word width; lengths saturate at 2^DATA_WIDTH-1
ADDR_WIDTH, 5, buffer address width; pointers are ADDR_WIDTH+1 bits
DEPTH, 32, buffer entries; must equal 2^ADDR_WIDTH
BYTES_PER_BEAT, 4, bytes per ingress beat
AFULL_TH, 28, fill count at or above which almost_full_o asserts

Ports:
int_buffer_clk  in  1  clock
int_buffer_rstn  in  1  reset, asynchronous, active-low
int_buffer_sw_rstn  in  1  synchronous soft reset, active-high
pkt_valid_i  in  1  ingress beat valid
pkt_sop_i  in  1  first beat of packet (qualified by valid)
pkt_eop_i  in  1  last beat of packet (qualified by valid)
pkt_last_bytes_i  in  $clog2(BYTES_PER_BEAT)+1  valid bytes on EOP beat; 0 means BYTES_PER_BEAT
len_rd_req_i  in  1  downstream request for the next length
wr_en_o  out  1  buffer write strobe
wr_addr_o  out  ADDR_WIDTH+1  write pointer
wr_data_o  out  DATA_WIDTH  packet length in bytes
rd_en_o  out  1  buffer read strobe
rd_addr_o  out  ADDR_WIDTH+1  read pointer
buffer_full_o  out  1  buffer full
buffer_empty_o  out  1  buffer empty
fill_cnt_o  out  ADDR_WIDTH+1  stored entries, range 0..DEPTH
almost_full_o  out  1  fill_cnt_o >= AFULL_TH
len_valid_o  out  1  buffer rd_data is valid this cycle
sop_err_o  out  1  sticky: SOP seen mid-packet
ovf_err_o  out  1  sticky: length dropped because buffer was full
sat_err_o  out  1  sticky: length saturated

Behaviour:
- Reset (async or soft): all pointers, the fill count and all outputs go to 0, except buffer_empty_o=1. The FSM returns to IDLE and the byte accumulator clears. Soft reset takes priority over all other activity in the same cycle. A packet in flight at reset is discarded.
- FSM has two states, IDLE and IN_PKT. A beat is any cycle with pkt_valid_i=1.
- IDLE:
  - SOP&EOP beat: single-beat packet; length = last_bytes; stay in IDLE.
  - SOP only: acc = BYTES_PER_BEAT; go to IN_PKT.
  - Beat without SOP: ignored.
- IN_PKT:
  - Non-EOP beat: acc += BYTES_PER_BEAT.
  - EOP beat: length = acc + last_bytes; go to IDLE.
  - SOP beat: set sop_err_o, discard the old packet, restart the accumulator as in IDLE. SOP&EOP on this beat completes a 1-beat packet.
- Arithmetic: the accumulator is DATA_WIDTH+1 bits internally and saturates at 2^DATA_WIDTH-1. On saturation, set sat_err_o and write the saturated value.
- Write stage, registered:
  - In the cycle after the EOP beat, wr_en_o=1, wr_data_o=length, wr_addr_o=current wr_ptr.
  - wr_ptr increments at the end of that cycle.
  - If buffer_full_o=1 in that cycle, wr_en_o stays 0, the length is dropped, ovf_err_o sets and wr_ptr holds.
  - wr_data_o holds its last value when wr_en_o=0.
- Read:
  - rd_en_o = len_rd_req_i & ~buffer_empty_o (combinational); rd_addr_o = rd_ptr.
  - rd_ptr increments at the end of a cycle with rd_en_o=1.
  - len_valid_o is a registered copy of rd_en_o, so the buffer's rd_data is valid in that cycle (1-cycle latency).
  - A request while empty is ignored with no error.
- Flags:
  - buffer_empty_o = (wr_ptr == rd_ptr).
  - buffer_full_o = MSBs differ and lower ADDR_WIDTH bits equal.
  - Pointers wrap naturally modulo 2^(ADDR_WIDTH+1).
  - fill_cnt_o = wr_ptr - rd_ptr, modulo 2^(ADDR_WIDTH+1).
  - All flags are combinational from registered pointers.
- Simultaneous write and read: both pointers advance and the count is unchanged. A read in the same cycle as a full-state write does not make room; that write is still dropped.
- Sticky errors clear only on reset.

Decomposition:
- Package pck_len_pkg holds:
  - the FSM state enum: IDLE, IN_PKT;
  - the default widths;
  - a len_t typedef of DATA_WIDTH bits.
- One sub-module: pck_len_acc, the beat accumulator with saturation.
- Pointer and flag logic stays in the top module. The top module instantiates alongside pck_len_buffer, which is unchanged.

Test Plan:
- Reset, then a 3-beat packet with last_bytes=2 -> cycle after EOP: wr_en_o=1, wr_data_o=10, wr_addr_o=0. Then fill_cnt_o=1, buffer_empty_o=0.
- 32 single-beat packets (last_bytes=0) -> buffer_full_o=1, fill_cnt_o=32, wr_addr_o=6'b100000, almost_full_o set at count 28. A 33rd packet -> no wr_en_o, ovf_err_o=1.
- One entry stored, len_rd_req_i for 2 cycles -> rd_en_o=1 once with rd_addr_o=0, len_valid_o the next cycle, then buffer_empty_o=1 and the second request is ignored.
- fill_cnt_o=5, write and read in the same cycle -> fill_cnt_o stays 5 and both pointers advance. Also wrap: 40 write/read pairs -> pointers pass 63->0 with flags correct.
- SOP at beat 2 of an open packet -> sop_err_o=1, old packet not written; new 2-beat packet with last_bytes=4 -> wr_data_o=8.
- 1100-beat packet -> wr_data_o=4095, sat_err_o=1. Soft reset mid-packet -> no write, pointers 0, buffer_empty_o=1, errors cleared.
